// File: rtl/accum_cpu_core_if.sv
// ---------------------------------------------------------------------------
// accum_cpu_core_if
// Instruction-memory bus between the accumulator core and its program store.
//
// Handshake: none. This is a combinational read port. The core (master) holds
// imem_addr stable for the whole FETCH cycle, and the memory (slave) must
// return imem_data for that address within the same cycle. There is no
// valid/ready pair because every fetch completes in one cycle.
//
// Signals:
//   imem_addr  [PC_W-1:0]  instruction address (equals PC), master -> slave
//   imem_data  [15:0]      instruction word, slave -> master
// ---------------------------------------------------------------------------
interface accum_cpu_core_if #(
    parameter int PC_W = 5
);
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_data;

    modport master (output imem_addr, input imem_data);
    modport slave  (input imem_addr, output imem_data);
endinterface

// File: rtl/accum_cpu_core.sv
// ---------------------------------------------------------------------------
// accum_cpu_core
// Two-phase accumulator CPU: FETCH latches the instruction word, and EXEC
// applies it. An instruction completes every two cycles until HALT, which is
// absorbing until reset.
//
// Optional feature macro: ACCUM_CPU_STEP_EN. When it is defined, a `step`
// input gates FETCH -> EXEC. When it is undefined, the core free-runs.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   imem       instruction bus (master modport of accum_cpu_core_if)
//   acc        accumulator
//   carry      carry/borrow flag
//   halted     high in HALT state
//   rf_we      register-file write strobe, high during EXEC of ST
//   rf_addr    register field of the current IR
//   state_dbg  current FSM state (0 FETCH, 1 EXEC, 2 HALT)
//   step       single-step advance (ACCUM_CPU_STEP_EN only)
// ---------------------------------------------------------------------------
module accum_cpu_core #(
    parameter int DATA_W = 8,
    parameter int REGS   = 4,
    parameter int PC_W   = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    accum_cpu_core_if.master         imem,
    output logic [DATA_W-1:0]        acc,
    output logic                     carry,
    output logic                     halted,
    output logic                     rf_we,
    output logic [$clog2(REGS)-1:0]  rf_addr,
    output logic [1:0]               state_dbg
`ifdef ACCUM_CPU_STEP_EN
    ,
    input  logic                     step
`endif
);
    localparam int RA_W = $clog2(REGS);

    localparam logic [3:0] OP_LDI  = 4'h1, OP_LD  = 4'h2, OP_ST   = 4'h3,
                           OP_ADD  = 4'h4, OP_SUB = 4'h5, OP_AND  = 4'h6,
                           OP_OR   = 4'h7, OP_XOR = 4'h8, OP_ADDC = 4'h9,
                           OP_SHL  = 4'hA, OP_SHR = 4'hB, OP_JMP  = 4'hC,
                           OP_JZ   = 4'hD, OP_JC  = 4'hE, OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [15:0]       ir;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] regs [REGS];
    logic              fetch_go;

    logic [3:0]        opcode;
    logic [RA_W-1:0]   ir_r;
    logic [DATA_W-1:0] imm;
    logic [PC_W-1:0]   target;
    logic [DATA_W-1:0] rv;
    logic [DATA_W-1:0] acc_nxt;
    logic              carry_nxt;
    logic [PC_W-1:0]   pc_nxt;
    logic [DATA_W:0]   sum_w;

    // Operand fields beyond DATA_W/PC_W/RA_W are ignored by design.
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir;

`ifdef ACCUM_CPU_STEP_EN
    assign fetch_go = step;
`else
    assign fetch_go = 1'b1;
`endif

    assign opcode         = ir[15:12];
    assign ir_r           = ir[RA_W-1:0];
    assign imm            = ir[DATA_W-1:0];
    assign target         = ir[PC_W-1:0];
    assign rv             = regs[ir_r];
    assign imem.imem_addr = pc;

    // ---- FSM: state register ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_FETCH;
        else      state <= state_nxt;
    end

    // ---- FSM: next-state logic ----
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: if (fetch_go) state_nxt = S_EXEC;
            S_EXEC:  state_nxt = (opcode == OP_HALT) ? S_HALT : S_FETCH;
            default: state_nxt = S_HALT;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        halted    = (state == S_HALT);
        rf_we     = (state == S_EXEC) && (opcode == OP_ST);
        rf_addr   = ir_r;
        state_dbg = state;
    end

    // ---- Execute datapath: result of the instruction held in IR ----
    always_comb begin
        acc_nxt   = acc;
        carry_nxt = carry;
        pc_nxt    = pc + PC_W'(1);
        sum_w     = '0;
        case (opcode)
            OP_LDI:  acc_nxt = imm;
            OP_LD:   acc_nxt = rv;
            OP_ADD: begin
                sum_w = {1'b0, acc} + {1'b0, rv};
                {carry_nxt, acc_nxt} = sum_w;
            end
            // The 9-bit difference's top bit is set exactly when A < R (borrow).
            OP_SUB: begin
                sum_w = {1'b0, acc} - {1'b0, rv};
                {carry_nxt, acc_nxt} = sum_w;
            end
            OP_AND:  acc_nxt = acc & rv;
            OP_OR:   acc_nxt = acc | rv;
            OP_XOR:  acc_nxt = acc ^ rv;
            OP_ADDC: begin
                sum_w = {1'b0, acc} + {1'b0, rv} + {{DATA_W{1'b0}}, carry};
                {carry_nxt, acc_nxt} = sum_w;
            end
            OP_SHL:  {carry_nxt, acc_nxt} = {acc, 1'b0};
            OP_SHR: begin
                carry_nxt = acc[0];
                acc_nxt   = {1'b0, acc[DATA_W-1:1]};
            end
            OP_JMP:  pc_nxt = target;
            OP_JZ:   if (acc == '0) pc_nxt = target;
            OP_JC:   if (carry) pc_nxt = target;
            OP_HALT: pc_nxt = pc;
            default: ;
        endcase
    end

    // ---- Architectural state ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir    <= '0;
            pc    <= '0;
            acc   <= '0;
            carry <= 1'b0;
            for (int i = 0; i < REGS; i++) regs[i] <= '0;
        end else begin
            if (state == S_FETCH && fetch_go) ir <= imem.imem_data;
            if (state == S_EXEC) begin
                acc   <= acc_nxt;
                carry <= carry_nxt;
                pc    <= pc_nxt;
                if (opcode == OP_ST) regs[ir_r] <= acc;
            end
        end
    end
endmodule

// File: tb/tb_accum_cpu_core.sv
// ---------------------------------------------------------------------------
// tb_accum_cpu_core
// Bench for accum_cpu_core (DATA_W=8, REGS=4, PC_W=5). An instruction-level
// reference model executes each instruction from the program array, and the
// core's architectural outputs are compared against it after every
// instruction. Directed programs come first, followed by random programs.
// ---------------------------------------------------------------------------
module tb_accum_cpu_core;
    logic       clk;
    logic       rst;
    logic [7:0] acc;
    logic       carry;
    logic       halted;
    logic       rf_we;
    logic [1:0] rf_addr;
    logic [1:0] state_dbg;
    logic [4:0] imem_addr;
`ifdef ACCUM_CPU_STEP_EN
    logic       step;
`endif

    logic [15:0] prog [32];

    accum_cpu_core_if #(.PC_W(5)) imem_bus ();
    assign imem_bus.imem_data = prog[imem_bus.imem_addr];
    assign imem_addr          = imem_bus.imem_addr;

    accum_cpu_core #(.DATA_W(8), .REGS(4), .PC_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .imem      (imem_bus.master),
        .acc       (acc),
        .carry     (carry),
        .halted    (halted),
        .rf_we     (rf_we),
        .rf_addr   (rf_addr),
        .state_dbg (state_dbg)
`ifdef ACCUM_CPU_STEP_EN
        ,
        .step      (step)
`endif
    );

    // ---- clock ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- scoreboard counters ----
    int errors = 0;
    int checks = 0;

    // ---- reference model state ----
    logic [7:0] m_acc;
    logic       m_c;
    logic [7:0] m_regs [4];
    int         m_pc;
    bit         m_halt;

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [11:0] opd);
        return {op, opd};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 8'h00;
        m_c = 1'b0;
        m_pc = 0;
        m_halt = 1'b0;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    endtask

    // Instruction-set semantics with plain integer arithmetic.
    task automatic model_exec(input logic [15:0] instr);
        int op, r, s, nxt;
        op  = int'(instr[15:12]);
        r   = int'(instr[1:0]);
        nxt = (m_pc + 1) % 32;
        case (op)
            1:  m_acc = instr[7:0];
            2:  m_acc = m_regs[r];
            3:  m_regs[r] = m_acc;
            4:  begin s = m_acc + m_regs[r]; m_c = (s > 255); m_acc = 8'(s % 256); end
            5:  begin m_c = (m_acc < m_regs[r]); m_acc = 8'((m_acc + 256 - m_regs[r]) % 256); end
            6:  m_acc = m_acc & m_regs[r];
            7:  m_acc = m_acc | m_regs[r];
            8:  m_acc = m_acc ^ m_regs[r];
            9:  begin s = m_acc + m_regs[r] + m_c; m_c = (s > 255); m_acc = 8'(s % 256); end
            10: begin s = m_acc * 2; m_c = (m_acc >= 128); m_acc = 8'(s % 256); end
            11: begin m_c = m_acc[0]; m_acc = m_acc / 2; end
            12: nxt = int'(instr[4:0]);
            13: if (m_acc == 0) nxt = int'(instr[4:0]);
            14: if (m_c) nxt = int'(instr[4:0]);
            15: begin m_halt = 1'b1; nxt = m_pc; end
            default: ;
        endcase
        m_pc = nxt;
    endtask

    // Reset the core and the model and check reset values. The task starts and ends at a negedge.
    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        check("rst_acc", acc, 0);
        check("rst_carry", carry, 0);
        check("rst_pc", imem_addr, 0);
        check("rst_halted", halted, 0);
        check("rst_rf_we", rf_we, 0);
        rst = 1'b1;
    endtask

    // Run one instruction (two cycles) and compare against the model.
    task automatic step_instr(input string tag);
        logic [15:0] instr;
        int          op;
        if (m_halt) begin
            repeat (2) @(negedge clk);
            check({tag, "_halted"}, halted, 1);
            check({tag, "_pc_frozen"}, imem_addr, m_pc);
            check({tag, "_acc_frozen"}, acc, m_acc);
            return;
        end
        instr = prog[m_pc];
        op    = int'(instr[15:12]);
        check({tag, "_fetch_addr"}, imem_addr, m_pc);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_rf_we"}, rf_we, (op == 3));
        if (op >= 2 && op <= 9) check({tag, "_rf_addr"}, rf_addr, instr[1:0]);
        @(posedge clk);
        @(negedge clk);
        model_exec(instr);
        check({tag, "_acc"}, acc, m_acc);
        check({tag, "_carry"}, carry, m_c);
        check({tag, "_pc"}, imem_addr, m_pc);
        check({tag, "_halted"}, halted, m_halt);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 32; i++) prog[i] = 16'h0000;
    endtask

    initial begin
        rst = 1'b0;
`ifdef ACCUM_CPU_STEP_EN
        step = 1'b1;
`endif
        clear_prog();
        @(negedge clk);

        // ---- arithmetic ----
        prog[0] = ins(4'h1, 12'h005);
        prog[1] = ins(4'h3, 12'h001);
        prog[2] = ins(4'h1, 12'h003);
        prog[3] = ins(4'h4, 12'h001);
        prog[4] = ins(4'hF, 12'h000);
        do_reset();
        for (int i = 0; i < 5; i++) step_instr("arith");
        check("arith_acc8", acc, 8'h08);
        check("arith_c0", carry, 0);
        check("arith_halted", halted, 1);
        repeat (4) @(negedge clk);
        check("arith_pc_frozen4", imem_addr, 4);
        check("arith_still_halted", halted, 1);

        // ---- carry chain ----
        clear_prog();
        prog[0] = ins(4'h1, 12'h0FF);
        prog[1] = ins(4'h3, 12'h000);
        prog[2] = ins(4'h1, 12'h001);
        prog[3] = ins(4'h4, 12'h000);
        prog[4] = ins(4'h9, 12'h000);
        prog[5] = ins(4'h1, 12'h001);
        prog[6] = ins(4'h5, 12'h000);
        prog[7] = ins(4'hF, 12'h000);
        do_reset();
        for (int i = 0; i < 4; i++) step_instr("cc");
        check("cc_add_acc", acc, 8'h00);
        check("cc_add_c", carry, 1);
        step_instr("cc");
        check("cc_addc_acc", acc, 8'h00);
        check("cc_addc_c", carry, 1);
        step_instr("cc");
        step_instr("cc");
        check("cc_sub_acc", acc, 8'h02);
        check("cc_sub_borrow", carry, 1);
        step_instr("cc");

        // ---- shifts and logic ----
        clear_prog();
        prog[0] = ins(4'h1, 12'h081);
        prog[1] = ins(4'hA, 12'h000);
        prog[2] = ins(4'hB, 12'h000);
        prog[3] = ins(4'h3, 12'h001);
        prog[4] = ins(4'h8, 12'h001);
        prog[5] = ins(4'hF, 12'h000);
        do_reset();
        step_instr("sh");
        step_instr("sh");
        check("shl_acc", acc, 8'h02);
        check("shl_c", carry, 1);
        step_instr("sh");
        check("shr_acc", acc, 8'h01);
        check("shr_c", carry, 0);
        step_instr("sh");
        step_instr("sh");
        check("xor_acc", acc, 8'h00);
        check("xor_c", carry, 0);
        step_instr("sh");

        // ---- countdown loop with JZ exit, then JC ----
        clear_prog();
        prog[0]  = ins(4'h1, 12'h001);
        prog[1]  = ins(4'h3, 12'h001);
        prog[2]  = ins(4'h1, 12'h003);
        prog[3]  = ins(4'h5, 12'h001);
        prog[4]  = ins(4'hD, 12'h006);
        prog[5]  = ins(4'hC, 12'h003);
        prog[6]  = ins(4'hE, 12'h00A);
        prog[7]  = ins(4'h5, 12'h001);
        prog[8]  = ins(4'hE, 12'h00A);
        prog[9]  = ins(4'hF, 12'h000);
        prog[10] = ins(4'hF, 12'h000);
        do_reset();
        for (int i = 0; i < 30 && !m_halt; i++) step_instr("loop");
        check("loop_halted", halted, 1);
        check("loop_halt_pc", imem_addr, 10);
        check("loop_acc", acc, 8'hFF);
        check("loop_c", carry, 1);

        // ---- PC wrap ----
        clear_prog();
        do_reset();
        for (int i = 0; i < 32; i++) step_instr("wrap");
        check("wrap_pc0", imem_addr, 0);

        // ---- reset during EXEC of ST ----
        clear_prog();
        prog[0] = ins(4'h1, 12'h055);
        prog[1] = ins(4'h3, 12'h002);
        prog[2] = ins(4'hF, 12'h000);
        do_reset();
        step_instr("mid");
        @(posedge clk);
        @(negedge clk);
        check("mid_rf_we", rf_we, 1);
        rst = 1'b0;
        #1;
        check("mid_acc0", acc, 0);
        check("mid_c0", carry, 0);
        check("mid_pc0", imem_addr, 0);
        check("mid_rf_we0", rf_we, 0);
        prog[0] = ins(4'h2, 12'h002);
        prog[1] = ins(4'hF, 12'h000);
        @(negedge clk);
        do_reset();
        step_instr("mid_ld");
        check("mid_r2_zero", acc, 0);
        step_instr("mid_ld");

`ifdef ACCUM_CPU_STEP_EN
        // ---- single step ----
        clear_prog();
        prog[0] = ins(4'h1, 12'h011);
        prog[1] = ins(4'h1, 12'h022);
        prog[2] = ins(4'hF, 12'h000);
        step = 1'b0;
        do_reset();
        repeat (5) @(negedge clk);
        check("step_hold_pc", imem_addr, 0);
        check("step_hold_acc", acc, 0);
        for (int n = 0; n < 2; n++) begin
            step = 1'b1;
            @(posedge clk);
            @(negedge clk);
            step = 1'b0;
            @(posedge clk);
            @(negedge clk);
            model_exec(prog[m_pc]);
            check("step_acc", acc, m_acc);
            check("step_pc", imem_addr, m_pc);
            repeat (5) @(negedge clk);
            check("step_held_acc", acc, m_acc);
            check("step_held_pc", imem_addr, m_pc);
        end
        step = 1'b1;
`endif

        // ---- random programs ----
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 32; k++)
                prog[k] = ins(4'($urandom_range(0, 14)), 12'($urandom));
            do_reset();
            for (int i = 0; i < 40; i++) step_instr("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/accum_cpu_core.md
# accum_cpu_core

Parametrised two-phase accumulator CPU core with an internal register file, carry flag, conditional branches and halt. It fetches instructions from an external combinational instruction memory, executes one instruction every two cycles, and exposes architectural state for observation. It is the successor to the fixed 8-bit, 4-register, straight-line accumulator datapath, and adds branching, carry-chained arithmetic, shifts and a halt state.

## Interface
- DATA_W, 8: accumulator/register width; legal range 4..12.
- REGS, 4: register count; power of two, 2..16; RA_W = clog2(REGS).
- PC_W, 5: program counter width; legal range 2..12; program space 2^PC_W words.
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- imem_addr  output  PC_W  instruction address; equals PC.
- imem_data  input  16  instruction word; combinational function of imem_addr.
- acc  output  DATA_W  accumulator.
- carry  output  1  carry/borrow flag.
- halted  output  1  high in HALT state.
- rf_we  output  1  register file write strobe; one EXEC cycle per ST.
- rf_addr  output  RA_W  register address field of the current IR.
- step  input  1  single-step advance; present only with ACCUM_CPU_STEP_EN.

## Operation
- Instruction format: [15:12] opcode, [11:0] operand. r = operand[RA_W-1:0]; imm = operand[DATA_W-1:0]; target = operand[PC_W-1:0].
- Opcodes: 0 NOP; 1 LDI A=imm; 2 LD A=R[r]; 3 ST R[r]=A; 4 ADD {C,A}=A+R[r]; 5 SUB {C,A}=A-R[r], C=borrow; 6 AND; 7 OR; 8 XOR (logic ops leave C unchanged); 9 ADDC {C,A}=A+R[r]+C; A SHL {C,A}={A,0}; B SHR C=A[0], A=A>>1; C JMP; D JZ (taken if A==0); E JC (taken if C==1); F HALT.
- Only ADD, SUB, ADDC, SHL and SHR write C. LD, LDI and ST leave C unchanged.
- FSM states: FETCH, EXEC, HALT.
  - FETCH: IR <= imem_data, then go to EXEC.
  - EXEC: apply the instruction. PC <= target for JMP or a taken branch; otherwise PC <= PC+1, mod 2^PC_W, so PC wraps from 2^PC_W-1 to 0. Then go to FETCH. HALT goes to HALT instead and leaves PC unchanged.
  - HALT: absorbing. Nothing changes until reset.
- Branch conditions use A and C as they stand at the start of EXEC.
- ST write and every other state update take effect at the end of EXEC. An LD immediately after an ST to the same register reads the new value.
- Reset values: PC 0, A 0, C 0, all registers 0, IR 0, state FETCH, halted 0, rf_we 0.
- Reset asserted mid-instruction aborts the instruction with no partial update; all state returns to its reset value.

## Timing
- Two cycles per instruction, except HALT.
- First FETCH occurs in the first clk edge after rst deasserts.
- Instruction at PC fetched at edge k; its results are visible at outputs after edge k+1.
- imem_addr is stable for the whole FETCH cycle. The memory must return imem_data within that cycle.
- rf_we is high during EXEC of ST only. rf_addr is valid whenever IR holds a register-type opcode.
- halted rises after the EXEC edge of HALT and stays high.

## Configuration
- ACCUM_CPU_STEP_EN defined: the step port exists, and FETCH advances to EXEC only on an edge where step=1. Otherwise the core stays in FETCH with IR and PC held. EXEC always completes. step has no effect in HALT.
- ACCUM_CPU_STEP_EN undefined: no step port. The core free-runs.

## Test plan
- Arithmetic: program LDI 5; ST r1; LDI 3; ADD r1; HALT. Required result: acc=8, carry=0, R1=5, halted=1 after 10 cycles, imem_addr frozen at 4.
- Carry chain: program LDI 0xFF; ST r0; LDI 1; ADD r0; ADDC r0. Required results: after ADD acc=0x00, carry=1; after ADDC acc=0x00, carry=1 (0+0xFF+1). Then LDI 1; SUB r0 gives acc=0x02, carry=1 (borrow).
- Shifts and logic: program LDI 0x81; SHL; SHR. After SHL: acc=0x02, carry=1. After SHR: acc=0x01, carry=0. Then XOR with R=0x01 gives acc=0x00 with carry unchanged at 0.
- Branches and wrap: run a countdown loop that decrements from 3 via SUB, with JZ exiting the loop. JZ is not taken for 2 and 1 and is taken at 0. Separately, NOP at PC=31 (PC_W=5) must fetch next from PC 0. JC is taken only when carry=1.
- Reset mid-operation: assert rst low during EXEC of ST r2 (A=0x55). Required response: R2 stays 0; acc, carry and PC go to 0 immediately; fetch restarts from 0.
- Step (macro on): hold step=0 for 5 cycles, then imem_addr and acc stay unchanged. Each single step=1 pulse advances exactly one instruction.
